// File: rtl/mfhwt_pkg.sv
// Shared defaults and width helpers for the MFHWT ping-pong buffer.
package mfhwt_pkg;

    localparam int MFHWT_DATA_W = 16;
    localparam int MFHWT_LANES  = 4;
    localparam int MFHWT_DEPTH  = 160;

    // Level/write-pointer width: must hold 0..depth inclusive.
    function automatic int LVL_W(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Entry index width within one bank: holds 0..depth-1.
    function automatic int PTR_W(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mfhwt_sdp_ram.sv
// One lane of storage: simple dual-port RAM, one write port and a registered read port.
module mfhwt_sdp_ram
    import mfhwt_pkg::*;
#(
    parameter int DATA_W = MFHWT_DATA_W,
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Address MSB selects the bank, so each bank spans a power-of-two window.
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/mfhwt_pingpong_buffer.sv
// Multi-lane double-banked ping-pong buffer: per-lane writers fill one bank while one reader drains the other.
module mfhwt_pingpong_buffer
    import mfhwt_pkg::*;
#(
    parameter int DATA_W = MFHWT_DATA_W,
    parameter int LANES  = MFHWT_LANES,
    parameter int DEPTH  = MFHWT_DEPTH
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic [LANES-1:0]        iWrreq,
    input  logic [DATA_W-1:0]       iData,
    input  logic                    iRdreq,
    output logic [LANES-1:0]        oFull,
    output logic                    oEmpty,
    output logic [LVL_W(DEPTH)-1:0] oLevel,
    output logic [LANES*DATA_W-1:0] oData,
    output logic                    oValid,
    output logic                    oOvf,
    output logic                    oUdf
);

    localparam int LW = LVL_W(DEPTH);
    localparam int AW = PTR_W(DEPTH);

    logic          r_wsel;
    logic [LW-1:0] r_wptr [LANES];
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_valid;
    logic          r_ovf;
    logic          r_udf;

    logic [LANES-1:0] w_full;
    logic [LANES-1:0] w_wen;
    logic             w_empty;
    logic             w_rd;
    logic             w_swap;

    always_comb begin
        w_full = '0;
        w_wen  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_full[i] = (r_wptr[i] == LW'(DEPTH));
            w_wen[i]  = iWrreq[i] & ~w_full[i];
        end
        w_empty = (r_level == '0);
        w_rd    = iRdreq & ~w_empty;
        // Swap cycle is both full and empty, so any request in it is dropped and flagged.
        w_swap  = (&w_full) & w_empty;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_wsel  <= 1'b0;
            r_rptr  <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_wptr[i] <= '0;
            end
        end else begin
            if (w_swap) begin
                r_wsel  <= ~r_wsel;
                r_rptr  <= '0;
                r_level <= LW'(DEPTH);
                for (int i = 0; i < LANES; i++) begin
                    r_wptr[i] <= '0;
                end
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    if (w_wen[i]) begin
                        r_wptr[i] <= r_wptr[i] + LW'(1);
                    end
                end
                if (w_rd) begin
                    r_rptr  <= r_rptr + AW'(1);
                    r_level <= r_level - LW'(1);
                end
            end
            r_valid <= w_rd;
            if (|(iWrreq & w_full)) begin
                r_ovf <= 1'b1;
            end
            if (iRdreq && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mfhwt_sdp_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (AW + 1)
        ) u_ram (
            .i_clk   (iClk),
            .i_rst_n (iRst_n),
            .i_we    (w_wen[g]),
            .i_waddr ({r_wsel, r_wptr[g][AW-1:0]}),
            .i_wdata (iData),
            .i_re    (w_rd),
            .i_raddr ({~r_wsel, r_rptr}),
            .o_rdata (oData[g*DATA_W +: DATA_W])
        );
    end

    assign oFull  = w_full;
    assign oEmpty = w_empty;
    assign oLevel = r_level;
    assign oValid = r_valid;
    assign oOvf   = r_ovf;
    assign oUdf   = r_udf;

endmodule
